// File: rtl/cam_pkg.sv
// Shared widths and FSM encoding for the CAM lookup match-iterator path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_pkg;

  localparam int MATCH_W = 32;
  localparam int IDX_W   = 5;
  localparam int TAG_W   = 8;

  // Explicit single-bit encoding keeps the state register legacy-compatible.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/prienc_32_5.sv
// LSB-first priority encoder: index of the lowest set bit of a 32-bit vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: vec - input vector; idx - lowest set bit index, 0 when vec is zero.
module prienc_32_5
  import cam_pkg::*;
(
  input  logic [MATCH_W-1:0] vec,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = MATCH_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cam_match_iter.sv
// Serialises one CAM match vector per lookup into matching entry indices, lowest first.
// Latency: accept at edge N -> first beat valid in cycle N+1; one index per cycle.
// Backpressure: beats hold stable while out_valid & !out_ready; in_ready only in IDLE.
// Ports: in_valid/in_ready/in_match/in_tag - lookup input; abort - drop rest of lookup;
//        out_valid/out_ready/out_idx/out_hit/out_last/out_trunc/out_tag - beat stream;
//        stat_lookups/stat_trunc - counters, built only with CAM_MATCH_ITER_STATS_EN.
module cam_match_iter
  import cam_pkg::*;
#(
  parameter int MAX_HITS = 32  // 1..32 hit beats per lookup; extra matches dropped
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MATCH_W-1:0] in_match,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_hit,
  output logic               out_last,
  output logic               out_trunc,
  output logic [TAG_W-1:0]   out_tag,
  output logic [31:0]        stat_lookups,
  output logic [31:0]        stat_trunc
);

  localparam logic [5:0] LAST_CNT = 6'(MAX_HITS - 1);

  state_t             state;
  logic [MATCH_W-1:0] pend;
  logic [TAG_W-1:0]   tag;
  logic [5:0]         cnt;

  logic [IDX_W-1:0]   enc_idx;
  logic [MATCH_W-1:0] pend_next;
  logic               single;
  logic               accept;
  logic               beat_hs;

  prienc_32_5 u_prienc (
    .vec (pend),
    .idx (enc_idx)
  );

  // pend is forced to zero whenever the FSM leaves EMIT, so in IDLE the
  // hit/trunc flags fall out as 0 and out_last as 1 with no extra gating.
  assign single    = (pend & (pend - 1'b1)) == '0;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = enc_idx;
  assign out_hit   = |pend;
  assign out_last  = !out_hit || single || (cnt == LAST_CNT);
  assign out_trunc = out_last && out_hit && !single;
  assign out_tag   = tag;

  assign accept    = in_ready && in_valid;
  assign beat_hs   = out_valid && out_ready;
  assign pend_next = pend & ~(MATCH_W'(1) << enc_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      tag   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort is meaningless here; a pending lookup is taken as usual.
          if (in_valid) begin
            pend  <= in_match;
            tag   <= in_tag;
            cnt   <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (beat_hs) begin
            pend <= pend_next;
            cnt  <= cnt + 6'd1;
            if (out_last) begin
              // Clearing here also drops matches left over by truncation.
              pend  <= '0;
              state <= IDLE;
            end
          end
          // A beat handshaken alongside abort has already been delivered.
          if (abort) begin
            pend  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAM_MATCH_ITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_trunc   <= '0;
    end else begin
      if (accept) stat_lookups <= stat_lookups + 32'd1;
      if (beat_hs && out_trunc) stat_trunc <= stat_trunc + 32'd1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_trunc   = '0;
`endif

endmodule
